// File: rtl/acc_alu_seq_pkg.sv
// Shared types for the registered accumulator ALU: opcodes, FSM states and the
// mnemonic cast used to display raw opcode bits as names in waveforms.
package acc_alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_LDI = 4'd8,
    OP_CLR = 4'd9,
    OP_SHL = 4'd10,
    OP_SHR = 4'd11,
    OP_ASR = 4'd12,
    OP_ROL = 4'd13,
    OP_ROR = 4'd14,
    OP_NOP = 4'd15
  } alu_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_t;

  function automatic alu_op_t op_mne(input logic [3:0] raw);
    return alu_op_t'(raw);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational W-bit add/subtract with carry-in; b is inverted when sub=1.
// Zero latency; no handshake.
module alu_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ov
);

  logic [W-1:0] w_b_eff;

  assign w_b_eff     = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, w_b_eff} + {{W{1'b0}}, cin};
  // Overflow: like-signed operands producing a result of the other sign.
  assign ov          = (a[W-1] == w_b_eff[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/acc_alu_seq.sv
// Registered accumulator ALU with Z/N/C/V flags; single-cycle ops finish in 1 cycle,
// shifts/rotates take count+1 cycles. start is ignored while busy (no queuing).
module acc_alu_seq
  import acc_alu_seq_pkg::*;
#(
  parameter int W = 8,
  localparam int CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  alu_op_t      op,
  input  logic [W-1:0] in_a,
  output logic [W-1:0] acc,
  output logic         z,
  output logic         neg,
  output logic         co,
  output logic         ov,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0]  W_VAL = W[W-1:0];
  localparam logic [CW-1:0] W_CNT = W[CW-1:0];

  alu_state_t   r_state, w_state_nxt;
  logic [W-1:0] r_acc;
  logic         r_z, r_n, r_c, r_v, r_done;
  logic [CW-1:0] r_cnt;
  alu_op_t      r_sop;

  logic          w_issue, w_is_shift, w_is_rot, w_go_shift, w_busy;
  logic [W-1:0]  w_mod;
  logic [CW-1:0] w_cnt;
  logic          w_sub, w_cin;
  logic [W-1:0]  w_sum;
  logic          w_cout, w_ov;
  logic [W-1:0]  w_nxt_acc, w_step_acc;
  logic          w_nxt_c, w_nxt_v, w_step_c;

  assign w_issue    = start && (r_state == ST_IDLE);
  assign w_is_rot   = (op == OP_ROL) || (op == OP_ROR);
  assign w_is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) || w_is_rot;
  assign w_mod      = in_a % W_VAL;

  always_comb begin
    w_cnt = '0;
    if (w_is_rot)
      w_cnt = w_mod[CW-1:0];
    else if (in_a >= W_VAL)
      w_cnt = W_CNT;
    else
      w_cnt = in_a[CW-1:0];
  end

  assign w_go_shift = w_issue && w_is_shift && (w_cnt != '0);

  assign w_sub = (op == OP_SUB) || (op == OP_SBC);
  assign w_cin = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : r_c;

  alu_addsub #(.W(W)) u_addsub (
    .a    (r_acc),
    .b    (in_a),
    .cin  (w_cin),
    .sub  (w_sub),
    .sum  (w_sum),
    .cout (w_cout),
    .ov   (w_ov)
  );

  // Result of a single-cycle op (also covers zero-count shifts).
  always_comb begin
    w_nxt_acc = r_acc;
    w_nxt_c   = r_c;
    w_nxt_v   = r_v;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        w_nxt_acc = w_sum;
        w_nxt_c   = w_cout;
        w_nxt_v   = w_ov;
      end
      OP_AND: w_nxt_acc = r_acc & in_a;
      OP_OR:  w_nxt_acc = r_acc | in_a;
      OP_XOR: w_nxt_acc = r_acc ^ in_a;
      OP_NOT: w_nxt_acc = ~r_acc;
      OP_LDI: w_nxt_acc = in_a;
      OP_CLR: begin
        w_nxt_acc = '0;
        w_nxt_c   = 1'b0;
        w_nxt_v   = 1'b0;
      end
      OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR: w_nxt_v = 1'b0;
      default: begin
        w_nxt_acc = r_acc;
      end
    endcase
  end

  // One bit position of the latched shift/rotate.
  always_comb begin
    w_step_acc = r_acc;
    w_step_c   = r_c;
    case (r_sop)
      OP_SHL: begin w_step_acc = {r_acc[W-2:0], 1'b0};       w_step_c = r_acc[W-1]; end
      OP_SHR: begin w_step_acc = {1'b0, r_acc[W-1:1]};       w_step_c = r_acc[0];   end
      OP_ASR: begin w_step_acc = {r_acc[W-1], r_acc[W-1:1]}; w_step_c = r_acc[0];   end
      OP_ROL: begin w_step_acc = {r_acc[W-2:0], r_acc[W-1]}; w_step_c = r_acc[W-1]; end
      OP_ROR: begin w_step_acc = {r_acc[0], r_acc[W-1:1]};   w_step_c = r_acc[0];   end
      default: begin
        w_step_acc = r_acc;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_go_shift) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == CW'(1)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == ST_SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_z    <= 1'b1;
      r_n    <= 1'b0;
      r_c    <= 1'b0;
      r_v    <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_sop  <= OP_NOP;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_SHIFT) begin
        r_acc <= w_step_acc;
        r_c   <= w_step_c;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_z    <= (w_step_acc == '0);
          r_n    <= w_step_acc[W-1];
          r_done <= 1'b1;
        end
      end else if (w_go_shift) begin
        r_cnt <= w_cnt;
        r_sop <= op;
        r_v   <= 1'b0;
      end else if (w_issue) begin
        r_acc  <= w_nxt_acc;
        r_c    <= w_nxt_c;
        r_v    <= w_nxt_v;
        r_z    <= (w_nxt_acc == '0);
        r_n    <= w_nxt_acc[W-1];
        r_done <= 1'b1;
      end
    end
  end

  assign acc  = r_acc;
  assign z    = r_z;
  assign neg  = r_n;
  assign co   = r_c;
  assign ov   = r_v;
  assign busy = w_busy;
  assign done = r_done;

endmodule

// File: doc/acc_alu_seq.md
Name: acc_alu_seq

Overview:
- Parametrised, registered successor to the combinational accumulator ALU.
- Holds the accumulator and the Z/N/C/V flags in registers and adds carry-chained arithmetic (ADC/SBC) and rotate.
- Shifts and rotates are multi-cycle, one bit position per clock, behind a start/busy/done handshake.
- Sits between the decoder/control unit and the register file/data memory; control issues one op at a time and waits for done.

Parameters:
- W, 8, datapath and accumulator width in bits (W >= 2).
- CW, $clog2(W)+1, shift-count width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue strobe; sampled only while busy=0.
- op  input  4  opcode, type alu_op_t from package definitions.
- in_a  input  W  operand / immediate / load data / shift count.
- acc  output  W  accumulator register.
- z  output  1  zero flag.
- neg  output  1  negative flag (acc[W-1]).
- co  output  1  carry flag.
- ov  output  1  signed overflow flag.
- busy  output  1  high while a multi-cycle op is in progress.
- done  output  1  one-cycle pulse when the issued op has written acc and flags.

Behaviour:
- Reset (asynchronous, active-high): acc=0, z=1, neg=0, co=0, ov=0, busy=0, done=0, state=IDLE, count=0. Reset mid-shift aborts the shift with no partial result retained.
- Issue: start && !busy in IDLE accepts op and in_a. start while busy is ignored; no queuing, no error.
- Single-cycle ops: result and flags are written at the edge that samples start, and done=1 for the following cycle. Back-to-back issue on consecutive cycles is legal.
  - ADD: {co,acc} = acc + in_a.
  - ADC: {co,acc} = acc + in_a + co.
  - SUB: {co,acc} = acc + ~in_a + 1. co=1 means no borrow.
  - SBC: {co,acc} = acc + ~in_a + co.
  - AND, OR, XOR: bitwise with in_a; co and ov unchanged.
  - NOT: acc = ~acc (bitwise, full width); co and ov unchanged.
  - LDI: acc = in_a; co and ov unchanged.
  - CLR: acc=0, co=0, ov=0, z=1, neg=0.
  - NOP: nothing changes; done still pulses.
- ov rule for ADD/ADC/SUB/SBC: set when both operand sign bits (with in_a inverted for SUB/SBC) match each other and differ from the result sign bit.
- Shift ops: SHL, SHR (logical), ASR, ROL, ROR.
  - count = min(in_a, W) for SHL/SHR/ASR; count = in_a mod W for ROL/ROR.
  - count==0: single-cycle; acc and co unchanged, z/neg refreshed, done next cycle.
  - count>0: go to SHIFT with busy=1 from the next cycle. Each cycle move one position and set co to the bit shifted or rotated out; count decrements.
  - On the cycle count reaches 1: final step, return to IDLE, busy=0 and done=1 in the following cycle.
  - Latency is count+1 cycles from start to done.
  - ov is cleared by all shifts.
- z and neg are recomputed from the new acc on every completing op.
- Unused op encodings behave as NOP.
- State machine: IDLE -> SHIFT (start, shift op, count>0); SHIFT -> SHIFT (count>1); SHIFT -> IDLE (count==1).

Decomposition:
- Package definitions:
  - alu_op_t enum, 4 bits: ADD, ADC, SUB, SBC, AND, OR, XOR, NOT, LDI, CLR, SHL, SHR, ASR, ROL, ROR, NOP.
  - alu_state_t enum: IDLE, SHIFT.
  - The op_mne-style mnemonic cast for waveform viewing.
- Sub-module alu_addsub: combinational W-bit adder taking a, b, cin and sub; outputs sum, cout, ov. Instantiated once.
- Shift stepping and the FSM stay in acc_alu_seq.

Test Plan:
- Reset then LDI 0x7F, ADD 0x01 -> acc=0x80, neg=1, ov=1, co=0, z=0, done pulses one cycle after each start.
- LDI 0xFF, ADD 0x01, ADC 0x00 -> after ADD: acc=0x00, z=1, co=1; after ADC: acc=0x01, co=0.
- LDI 0x05, SUB 0x07 -> acc=0xFE, co=0, neg=1. Then LDI 0x07, SUB 0x07 -> acc=0, z=1, co=1.
- LDI 0x81, SHL 3 -> busy high 3 cycles, done at cycle 4; acc=0x08, co=0 (last bit out was 0). Then ASR with in_a=9 on acc=0x80 -> count clamps to 8, acc=0xFF.
- LDI 0x81, ROL 9 (count=1) -> acc=0x03, co=1. Also: start with op=ADD pulsed during a SHIFT -> ignored, acc unaffected.
- Assert reset during SHIFT cycle 2 -> acc=0, busy=0, done=0 immediately, with no clock edge needed; the next LDI 0x3C works normally.
